// File: rtl/pipe_pkg.sv
// pipe_pkg: shared forwarding codes and the per-stage shadow record for the hazard/forward unit
package pipe_pkg;
  localparam int STAGE_AW = 5;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  typedef struct packed {
    logic                valid;
    logic [STAGE_AW-1:0] src1;
    logic [STAGE_AW-1:0] src2;
    logic                src1_used;
    logic                src2_used;
    logic [STAGE_AW-1:0] dest;
    logic                wb_en;
    logic                is_load;
  } stage_info_t;
endpackage

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: ID decode, control inputs and EXE/hazard outputs of the forwarding unit
interface hazard_forward_unit_if #(parameter int REG_AW = 5, parameter int CNT_W = 16);
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_src1_used;
  logic              id_src2_used;
  logic [REG_AW-1:0] id_dest;
  logic              id_wb_en;
  logic              id_is_load;
  logic              flush;
  logic              mem_busy;
  logic [1:0]        val1_sel;
  logic [1:0]        val2_sel;
  logic              stall;
  logic              bubble;
  logic              freeze;
  logic [CNT_W-1:0]  stall_cnt;
  modport master (
    output id_valid, id_src1, id_src2, id_src1_used, id_src2_used, id_dest, id_wb_en, id_is_load,
           flush, mem_busy,
    input  val1_sel, val2_sel, stall, bubble, freeze, stall_cnt
  );
  modport slave (
    input  id_valid, id_src1, id_src2, id_src1_used, id_src2_used, id_dest, id_wb_en, id_is_load,
           flush, mem_busy,
    output val1_sel, val2_sel, stall, bubble, freeze, stall_cnt
  );
endinterface

// File: rtl/hazard_match.sv
// hazard_match: flags a pipeline stage that will write register r
module hazard_match
  import pipe_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [STAGE_AW-1:0] r,
  input  stage_info_t         s,
  output logic                hit
);
  assign hit = s.valid && s.wb_en && s.dest == r && !(ZERO_REG && r == '0);
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: shadow EX/MEM/WB destinations, EX operand forwarding selects,
// load-use / interlock stalls, memory-wait freeze and a saturating stall counter
module hazard_forward_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW           = STAGE_AW,
  parameter bit FWD_EN           = 1'b1,
  parameter bit RF_WRITE_THROUGH = 1'b1,
  parameter bit ZERO_REG         = 1'b1,
  parameter int CNT_W            = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_forward_unit_if.slave bus
);
  stage_info_t ex_q, mem_q, wb_q, ex_d, mem_d, wb_d, id_info;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [1:0][STAGE_AW-1:0] ex_src, id_src;
  logic [1:0] ex_used, id_used, ex_mem_hit, ex_wb_hit, id_ex_hit, id_mem_hit, id_wb_hit, id_dep;
  logic [1:0] sel [2];
  logic hazard, stall, bubble, freeze;
  assign ex_src  = {ex_q.src2, ex_q.src1};
  assign ex_used = {ex_q.src2_used, ex_q.src1_used};
  assign id_src  = {bus.id_src2, bus.id_src1};
  assign id_used = {bus.id_src2_used, bus.id_src1_used};
  for (genvar i = 0; i < 2; i++) begin : g_src
    hazard_match #(.ZERO_REG(ZERO_REG)) u_ex_mem (.r(ex_src[i]), .s(mem_q), .hit(ex_mem_hit[i]));
    hazard_match #(.ZERO_REG(ZERO_REG)) u_ex_wb  (.r(ex_src[i]), .s(wb_q),  .hit(ex_wb_hit[i]));
    hazard_match #(.ZERO_REG(ZERO_REG)) u_id_ex  (.r(id_src[i]), .s(ex_q),  .hit(id_ex_hit[i]));
    hazard_match #(.ZERO_REG(ZERO_REG)) u_id_mem (.r(id_src[i]), .s(mem_q), .hit(id_mem_hit[i]));
    hazard_match #(.ZERO_REG(ZERO_REG)) u_id_wb  (.r(id_src[i]), .s(wb_q),  .hit(id_wb_hit[i]));
    // MEM is the younger producer, so it wins over WB
    assign sel[i] = (!FWD_EN || !ex_q.valid || !ex_used[i]) ? FWD_RF :
                    ex_mem_hit[i] ? FWD_MEM : ex_wb_hit[i] ? FWD_WB : FWD_RF;
    assign id_dep[i] = id_used[i] && (FWD_EN ? (ex_q.is_load && id_ex_hit[i]) :
                       (id_ex_hit[i] || id_mem_hit[i] || (!RF_WRITE_THROUGH && id_wb_hit[i])));
  end
  assign hazard = bus.id_valid && |id_dep;
  assign freeze = bus.mem_busy;
  assign bubble = !bus.mem_busy && (bus.flush || hazard);
  assign stall  = !bus.mem_busy && !bus.flush && hazard;
  assign bus.val1_sel  = sel[0];
  assign bus.val2_sel  = sel[1];
  assign bus.stall     = stall;
  assign bus.bubble    = bubble;
  assign bus.freeze    = freeze;
  assign bus.stall_cnt = stall_cnt_q;
  always_comb begin
    id_info = '{valid: bus.id_valid, src1: bus.id_src1, src2: bus.id_src2,
                src1_used: bus.id_src1_used, src2_used: bus.id_src2_used,
                dest: bus.id_dest, wb_en: bus.id_wb_en, is_load: bus.id_is_load};
    ex_d  = bus.mem_busy ? ex_q : bubble ? stage_info_t'('0) : id_info;
    mem_d = bus.mem_busy ? mem_q : ex_q;
    wb_d  = bus.mem_busy ? wb_q : mem_q;
    stall_cnt_d = ((stall || freeze) && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed scenarios plus randomized traffic against a distance-based model,
// run on three configurations (default, ZERO_REG=0, interlock-only)
module tb_hazard_forward_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, id_src1_used, id_src2_used, id_wb_en, id_is_load, flush, mem_busy;
  logic [4:0] id_src1, id_src2, id_dest;
  logic [21:0] in_bus;
  int n_chk = 0;
  int n_fail = 0;

  hazard_forward_unit_if #(.REG_AW(5), .CNT_W(16)) i0 ();
  hazard_forward_unit_if #(.REG_AW(5), .CNT_W(16)) i1 ();
  hazard_forward_unit_if #(.REG_AW(5), .CNT_W(16)) i2 ();

  assign in_bus = {id_valid, id_src1, id_src2, id_src1_used, id_src2_used, id_dest, id_wb_en, id_is_load, flush, mem_busy};
  assign {i0.id_valid, i0.id_src1, i0.id_src2, i0.id_src1_used, i0.id_src2_used, i0.id_dest, i0.id_wb_en, i0.id_is_load, i0.flush, i0.mem_busy} = in_bus;
  assign {i1.id_valid, i1.id_src1, i1.id_src2, i1.id_src1_used, i1.id_src2_used, i1.id_dest, i1.id_wb_en, i1.id_is_load, i1.flush, i1.mem_busy} = in_bus;
  assign {i2.id_valid, i2.id_src1, i2.id_src2, i2.id_src1_used, i2.id_src2_used, i2.id_dest, i2.id_wb_en, i2.id_is_load, i2.flush, i2.mem_busy} = in_bus;

  hazard_forward_unit #(.FWD_EN(1'b1), .RF_WRITE_THROUGH(1'b1), .ZERO_REG(1'b1), .CNT_W(16)) d0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  hazard_forward_unit #(.FWD_EN(1'b1), .RF_WRITE_THROUGH(1'b1), .ZERO_REG(1'b0), .CNT_W(16)) d1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  hazard_forward_unit #(.FWD_EN(1'b0), .RF_WRITE_THROUGH(1'b1), .ZERO_REG(1'b1), .CNT_W(16)) d2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));

  logic [1:0]  o_s1 [3];
  logic [1:0]  o_s2 [3];
  logic        o_st [3];
  logic        o_bu [3];
  logic        o_fr [3];
  logic [15:0] o_cnt [3];
  assign o_s1  = '{i0.val1_sel, i1.val1_sel, i2.val1_sel};
  assign o_s2  = '{i0.val2_sel, i1.val2_sel, i2.val2_sel};
  assign o_st  = '{i0.stall, i1.stall, i2.stall};
  assign o_bu  = '{i0.bubble, i1.bubble, i2.bubble};
  assign o_fr  = '{i0.freeze, i1.freeze, i2.freeze};
  assign o_cnt = '{i0.stall_cnt, i1.stall_cnt, i2.stall_cnt};

  // Reference model: instructions ahead of ID, index 0 = one slot ahead (EX), 1 = two (MEM), 2 = three (WB)
  typedef struct {bit v; bit [4:0] s1, s2, d; bit u1, u2, we, ld;} ins_t;
  ins_t q [3][3];
  bit [15:0] mcnt [3];
  bit fwd [3] = '{1'b1, 1'b1, 1'b0};
  bit wt  [3] = '{1'b1, 1'b1, 1'b1};
  bit zr  [3] = '{1'b1, 1'b0, 1'b1};

  function automatic bit wr(int c, ins_t x, bit [4:0] r);
    return x.v && x.we && x.d == r && !(zr[c] && r == 5'd0);
  endfunction

  // forward code equals the distance from the EX consumer to its nearest producer
  function automatic bit [1:0] fsel(int c, bit u, bit [4:0] r);
    if (!fwd[c] || !q[c][0].v || !u) return 2'd0;
    for (int d = 1; d <= 2; d++) if (wr(c, q[c][d], r)) return 2'(d);
    return 2'd0;
  endfunction

  function automatic bit dep(int c, bit u, bit [4:0] r);
    if (!u) return 1'b0;
    if (fwd[c]) return q[c][0].ld && wr(c, q[c][0], r);
    for (int d = 0; d < (wt[c] ? 2 : 3); d++) if (wr(c, q[c][d], r)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic pos(); @(posedge clk); #1; endtask
  task automatic neg(); @(negedge clk); endtask

  task automatic nop();
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_src1_used = 0; id_src2_used = 0;
    id_dest = 0; id_wb_en = 0; id_is_load = 0; flush = 0; mem_busy = 0;
  endtask

  task automatic issue(input logic [4:0] s1, s2, d, input logic u1, u2, we, ld);
    id_valid = 1; id_src1 = s1; id_src2 = s2; id_src1_used = u1; id_src2_used = u2;
    id_dest = d; id_wb_en = we; id_is_load = ld;
  endtask

  task automatic do_reset();
    nop(); rst_n = 0; pos(); pos(); rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    issue(5'd1, 5'd0, 5'd5, 1, 0, 1, 1);
    pos();
    issue(5'd5, 5'd1, 5'd6, 1, 1, 1, 0);
    mem_busy = 1;
    pos();
    neg();
    n_chk++; if (i0.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL rst_pre_cnt got %0d want 1", i0.stall_cnt); end
    mem_busy = 0;
    #1;
    n_chk++; if (i0.stall !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall got %0b want 1", i0.stall); end
    #2 rst_n = 0;
    #1;
    n_chk++; if ({i0.val1_sel, i0.val2_sel, i0.stall, i0.bubble, i0.freeze} !== 7'd0) begin n_fail++; $display("FAIL rst_outputs got %b want 0000000", {i0.val1_sel, i0.val2_sel, i0.stall, i0.bubble, i0.freeze}); end
    n_chk++; if (i0.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", i0.stall_cnt); end
    nop();
    pos();
    rst_n = 1;
    neg();
    n_chk++; if ({i0.stall, i0.stall_cnt} !== 17'd0) begin n_fail++; $display("FAIL rst_release got %0h want 0", {i0.stall, i0.stall_cnt}); end
  endtask

  task automatic test_alu_chain();
    do_reset();
    issue(5'd1, 5'd2, 5'd3, 1, 1, 1, 0);
    pos();
    issue(5'd3, 5'd3, 5'd4, 1, 1, 1, 0);
    neg();
    n_chk++; if (i0.stall !== 1'b0) begin n_fail++; $display("FAIL alu_nostall got %0b want 0", i0.stall); end
    pos();
    nop();
    neg();
    n_chk++; if ({i0.val1_sel, i0.val2_sel} !== 4'b0101) begin n_fail++; $display("FAIL alu_mem_fwd got %b want 0101", {i0.val1_sel, i0.val2_sel}); end
    do_reset();
    issue(5'd1, 5'd2, 5'd3, 1, 1, 1, 0);
    pos();
    nop();
    pos();
    issue(5'd3, 5'd3, 5'd4, 1, 1, 1, 0);
    pos();
    nop();
    neg();
    n_chk++; if ({i0.val1_sel, i0.val2_sel} !== 4'b1010) begin n_fail++; $display("FAIL alu_wb_fwd got %b want 1010", {i0.val1_sel, i0.val2_sel}); end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(5'd1, 5'd0, 5'd5, 1, 0, 1, 1);
    pos();
    issue(5'd5, 5'd1, 5'd6, 1, 1, 1, 0);
    neg();
    n_chk++; if ({i0.stall, i0.bubble} !== 2'b11) begin n_fail++; $display("FAIL lu_stall got %b want 11", {i0.stall, i0.bubble}); end
    pos();
    neg();
    n_chk++; if ({i0.stall, i0.bubble} !== 2'b00) begin n_fail++; $display("FAIL lu_one_cycle got %b want 00", {i0.stall, i0.bubble}); end
    pos();
    nop();
    neg();
    n_chk++; if ({i0.val1_sel, i0.val2_sel} !== 4'b1000) begin n_fail++; $display("FAIL lu_fwd got %b want 1000", {i0.val1_sel, i0.val2_sel}); end
    n_chk++; if (i0.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt got %0d want 1", i0.stall_cnt); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    issue(5'd1, 5'd2, 5'd0, 1, 1, 1, 0);
    pos();
    issue(5'd0, 5'd0, 5'd7, 1, 1, 1, 0);
    neg();
    n_chk++; if ({i0.stall, i1.stall, i2.stall} !== 3'b000) begin n_fail++; $display("FAIL zr_nostall got %b want 000", {i0.stall, i1.stall, i2.stall}); end
    pos();
    nop();
    neg();
    n_chk++; if ({i0.val1_sel, i0.val2_sel} !== 4'b0000) begin n_fail++; $display("FAIL zr_sel got %b want 0000", {i0.val1_sel, i0.val2_sel}); end
    n_chk++; if ({i1.val1_sel, i1.val2_sel} !== 4'b0101) begin n_fail++; $display("FAIL zr_off_sel got %b want 0101", {i1.val1_sel, i1.val2_sel}); end
  endtask

  task automatic test_interlock();
    do_reset();
    issue(5'd1, 5'd1, 5'd2, 1, 1, 1, 0);
    pos();
    issue(5'd2, 5'd2, 5'd7, 1, 1, 1, 0);
    for (int k = 0; k < 2; k++) begin
      neg();
      n_chk++; if ({i2.stall, i2.bubble} !== 2'b11) begin n_fail++; $display("FAIL il_stall%0d got %b want 11", k, {i2.stall, i2.bubble}); end
      pos();
    end
    neg();
    n_chk++; if (i2.stall !== 1'b0) begin n_fail++; $display("FAIL il_release got %0b want 0", i2.stall); end
    pos();
    nop();
    neg();
    n_chk++; if ({i2.val1_sel, i2.val2_sel} !== 4'b0000) begin n_fail++; $display("FAIL il_sel got %b want 0000", {i2.val1_sel, i2.val2_sel}); end
    n_chk++; if (i2.stall_cnt !== 16'd2) begin n_fail++; $display("FAIL il_cnt got %0d want 2", i2.stall_cnt); end
  endtask

  task automatic test_freeze_flush();
    do_reset();
    issue(5'd1, 5'd0, 5'd5, 1, 0, 1, 1);
    pos();
    issue(5'd5, 5'd1, 5'd6, 1, 1, 1, 0);
    mem_busy = 1;
    for (int k = 0; k < 3; k++) begin
      neg();
      n_chk++; if ({i0.freeze, i0.stall, i0.bubble} !== 3'b100) begin n_fail++; $display("FAIL fz_cycle%0d got %b want 100", k, {i0.freeze, i0.stall, i0.bubble}); end
      pos();
    end
    mem_busy = 0;
    neg();
    n_chk++; if ({i0.freeze, i0.stall, i0.bubble} !== 3'b011) begin n_fail++; $display("FAIL fz_then_stall got %b want 011", {i0.freeze, i0.stall, i0.bubble}); end
    pos();
    pos();
    nop();
    neg();
    n_chk++; if (i0.val1_sel !== 2'b10) begin n_fail++; $display("FAIL fz_fwd got %b want 10", i0.val1_sel); end
    n_chk++; if (i0.stall_cnt !== 16'd4) begin n_fail++; $display("FAIL fz_cnt got %0d want 4", i0.stall_cnt); end
    do_reset();
    issue(5'd1, 5'd0, 5'd5, 1, 0, 1, 1);
    pos();
    issue(5'd5, 5'd1, 5'd6, 1, 1, 1, 0);
    flush = 1;
    neg();
    n_chk++; if ({i0.stall, i0.bubble} !== 2'b01) begin n_fail++; $display("FAIL fl_lu got %b want 01", {i0.stall, i0.bubble}); end
    pos();
    nop();
    neg();
    n_chk++; if ({i0.val1_sel, i0.val2_sel, i0.stall_cnt} !== 20'd0) begin n_fail++; $display("FAIL fl_killed got %h want 0", {i0.val1_sel, i0.val2_sel, i0.stall_cnt}); end
  endtask

  task automatic test_random();
    ins_t nq [3][3];
    bit [15:0] ncnt [3];
    ins_t cur;
    bit hz, e_st, e_bu, e_fr;
    bit [1:0] e1, e2;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      mcnt[c] = 0;
      for (int s = 0; s < 3; s++) q[c][s] = '{default: 0};
    end
    for (int n = 0; n < 600; n++) begin
      issue(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      id_valid = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 9) == 0;
      mem_busy = $urandom_range(0, 6) == 0;
      cur = '{v: id_valid, s1: id_src1, s2: id_src2, d: id_dest, u1: id_src1_used, u2: id_src2_used, we: id_wb_en, ld: id_is_load};
      neg();
      for (int c = 0; c < 3; c++) begin
        e1 = fsel(c, q[c][0].u1, q[c][0].s1);
        e2 = fsel(c, q[c][0].u2, q[c][0].s2);
        hz = cur.v && (dep(c, cur.u1, cur.s1) || dep(c, cur.u2, cur.s2));
        e_fr = mem_busy;
        e_bu = !mem_busy && (flush || hz);
        e_st = !mem_busy && !flush && hz;
        n_chk++; if (o_s1[c] !== e1) begin n_fail++; $display("FAIL rnd_sel1 cfg%0d cyc%0d got %b want %b", c, n, o_s1[c], e1); end
        n_chk++; if (o_s2[c] !== e2) begin n_fail++; $display("FAIL rnd_sel2 cfg%0d cyc%0d got %b want %b", c, n, o_s2[c], e2); end
        n_chk++; if ({o_st[c], o_bu[c], o_fr[c]} !== {e_st, e_bu, e_fr}) begin n_fail++; $display("FAIL rnd_ctl cfg%0d cyc%0d got %b want %b", c, n, {o_st[c], o_bu[c], o_fr[c]}, {e_st, e_bu, e_fr}); end
        n_chk++; if (o_cnt[c] !== mcnt[c]) begin n_fail++; $display("FAIL rnd_cnt cfg%0d cyc%0d got %0d want %0d", c, n, o_cnt[c], mcnt[c]); end
        ncnt[c] = ((e_st || e_fr) && mcnt[c] != 16'hffff) ? mcnt[c] + 16'd1 : mcnt[c];
        if (mem_busy) for (int s = 0; s < 3; s++) nq[c][s] = q[c][s];
        else begin
          nq[c][2] = q[c][1];
          nq[c][1] = q[c][0];
          nq[c][0] = e_bu ? '{default: 0} : cur;
        end
      end
      pos();
      for (int c = 0; c < 3; c++) begin
        mcnt[c] = ncnt[c];
        for (int s = 0; s < 3; s++) q[c][s] = nq[c][s];
      end
    end
  endtask

  initial begin
    nop();
    test_reset();
    test_alu_chain();
    test_load_use();
    test_zero_reg();
    test_interlock();
    test_freeze_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
